// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// No logic, no latency, no backpressure.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational ripple-carry slice: {cout,sum} = a + b + cin; zero latency.
// No handshake; the enclosing pipeline stage owns flow control.
module add_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipe_adder_nbit.sv
// Pipelined WIDTH-bit add/sub, one carry slice per stage; latency STAGES cycles.
// Global stall: every stage holds while the output beat is valid and not accepted.
module pipe_adder_nbit
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder_nbit: WIDTH must be a non-zero multiple of STAGES");
    end

    logic advance;
    logic accept;

    // x_* are the values entering slice k; r_* are the registers after slice k.
    logic [WIDTH-1:0] x_a   [STAGES];
    logic [WIDTH-1:0] x_b   [STAGES];
    logic [WIDTH-1:0] x_s   [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             x_c   [STAGES];
    logic             x_v   [STAGES];
    logic [SW-1:0]    sl_s  [STAGES];
    logic             sl_c  [STAGES];

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             zero_q;

    assign advance  = !r_v[STAGES-1] || out_ready;
    assign in_ready = advance && rst_n;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign x_a[0] = a;
            assign x_b[0] = (op_sub == OP_SUB) ? ~b : b;
            assign x_s[0] = '0;
            assign x_c[0] = (op_sub == OP_SUB) ? 1'b1 : cin;
            assign x_v[0] = accept;
        end else begin : g_body
            assign x_a[k] = r_a[k-1];
            assign x_b[k] = r_b[k-1];
            assign x_s[k] = r_s[k-1];
            assign x_c[k] = r_c[k-1];
            assign x_v[k] = r_v[k-1];
        end

        add_slice #(.SLICE_W(SW)) u_slice (
            .a    (x_a[k][k*SW +: SW]),
            .b    (x_b[k][k*SW +: SW]),
            .cin  (x_c[k]),
            .sum  (sl_s[k]),
            .cout (sl_c[k])
        );

        // Bits of slice k are still zero in x_s, so OR merges the new slice in.
        assign nxt_s[k] = x_s[k] | (WIDTH'(sl_s[k]) << (k * SW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= x_a[k];
                r_b[k] <= x_b[k];
                r_s[k] <= nxt_s[k];
                r_c[k] <= sl_c[k];
                r_v[k] <= x_v[k];
            end
            zero_q <= x_v[STAGES-1] && (nxt_s[STAGES-1] == '0);
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign zero      = zero_q;
    // Operand MSBs ride along to the last register so overflow needs no extra stage.
    assign ovf       = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
                       (r_s[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder_nbit.sv
// Directed bench for pipe_adder_nbit (16-bit/4-stage and 4-bit/1-stage instances).
module tb_pipe_adder_nbit;

    localparam int W = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, cin, op_sub;
    logic         out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, sum;

    logic         s_in_valid, s_in_ready, s_cin, s_op_sub;
    logic         s_out_valid, s_out_ready, s_cout, s_ovf, s_zero;
    logic [3:0]   s_a, s_b, s_sum;

    pipe_adder_nbit #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipe_adder_nbit #(.WIDTH(4), .STAGES(1)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .op_sub(s_op_sub), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout), .ovf(s_ovf), .zero(s_zero)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int delivered = 0;
    logic [18:0] exp_q[$];
    int pop_cyc[$];

    logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0001,
                            16'h7FFF, 16'hAAAA, 16'h0F0F, 16'hC350};
    logic [15:0] vb [8] = '{16'h4321, 16'h0001, 16'h8000, 16'hFFFF,
                            16'h7FFF, 16'h5555, 16'hF0F0, 16'h1388};
    logic        vc [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Returns {cout, ovf, zero, sum}.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sub);
        logic [15:0] yp;
        logic [16:0] r;
        logic        o;
        yp = sub ? ~y : y;
        r  = {1'b0, x} + {1'b0, yp} + {16'd0, (sub ? 1'b1 : ci)};
        o  = (x[15] == yp[15]) && (r[15] != x[15]);
        return {r[16], o, (r[15:0] == 16'd0), r[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled at the falling edge; control returns 1 time unit after the rising edge.
    task automatic tick(output bit acc);
        logic [18:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(a, b, cin, op_sub));
        if (out_valid && out_ready) begin
            delivered++;
            pop_cyc.push_back(cyc);
            chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", 32'({cout, ovf, zero, sum}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic one_beat(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic ci, input logic sub, input logic [15:0] es,
                            input logic ec, input logic eo, input logic ez);
        bit acc;
        in_valid = 1'b1; a = x; b = y; cin = ci; op_sub = sub;
        tick(acc);
        chk({tag, "_acc"}, 32'(acc), 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < S - 1; i++) begin
            chk({tag, "_early"}, 32'(out_valid), 32'd0);
            tick(acc);
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        tick(acc);
    endtask

    initial begin
        bit acc;
        int idx, d0;
        bit stalled;
        logic [19:0] held;
        logic [3:0] x4, y4, yn4;
        logic [4:0] e5;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_op_sub = 1'b0;
        s_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", 32'({cout, ovf, zero}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed corner cases
        one_beat("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        one_beat("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        one_beat("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        one_beat("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        one_beat("add_cin",  16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream at full throughput
        pop_cyc.delete();
        d0 = delivered;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; op_sub = vs[i];
            tick(acc);
            chk("b2b_acc", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        repeat (8) tick(acc);
        chk("b2b_count", 32'(delivered - d0), 32'd8);
        if (pop_cyc.size() == 8)
            chk("b2b_consecutive", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Stream with a 3-cycle output stall
        d0 = delivered;
        idx = 0;
        stalled = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (idx >= 6 && exp_q.size() == 0) break;
            if (!stalled && out_valid) begin
                stalled = 1'b1;
                held = {out_valid, cout, ovf, zero, sum};
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    in_valid = (idx < 6);
                    a = va[idx % 8]; b = vb[idx % 8]; cin = vc[idx % 8]; op_sub = vs[idx % 8];
                    #1;
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    tick(acc);
                    chk("stall_acc", 32'(acc), 32'd0);
                    chk("stall_hold", 32'({out_valid, cout, ovf, zero, sum}), 32'(held));
                end
                out_ready = 1'b1;
            end
            in_valid = (idx < 6);
            a = va[idx % 8]; b = vb[idx % 8]; cin = vc[idx % 8]; op_sub = vs[idx % 8];
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("stall_seen", 32'(stalled), 32'd1);
        chk("stall_count", 32'(delivered - d0), 32'd6);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset with beats in flight
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; cin = 1'b0; op_sub = 1'b0;
            a = (i == 0) ? 16'hFFFF : va[i];
            b = (i == 0) ? 16'hFFFF : vb[i];
            tick(acc);
        end
        in_valid = 1'b0;
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        chk("pre_rst_sum", 32'(sum), 32'hFFFE);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_flags", 32'({cout, ovf, zero}), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        tick(acc);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        d0 = delivered;
        for (int i = 0; i < 8; i++) begin
            chk("after_rst_quiet", 32'(out_valid), 32'd0);
            tick(acc);
        end
        chk("after_rst_none", 32'(delivered - d0), 32'd0);
        one_beat("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Exhaustive 4-bit, single-stage instance
        for (int i = 0; i < 1024; i++) begin
            x4 = i[3:0]; y4 = i[7:4];
            s_in_valid = 1'b1; s_a = x4; s_b = y4; s_cin = i[8]; s_op_sub = i[9];
            yn4 = ~y4;
            e5 = i[9] ? ({1'b0, x4} + {1'b0, yn4} + 5'd1)
                      : ({1'b0, x4} + {1'b0, y4} + {4'd0, i[8]});
            @(posedge clk);
            #1;
            chk("w4_vld", 32'(s_out_valid), 32'd1);
            chk("w4_res", 32'({s_cout, s_sum}), 32'(e5));
        end
        s_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
